mode_param_gen: RTL
===================

// Module: mode_param_gen
// PURPOSE
//  Per-pixel tone-mapping parameter generator with frame-synchronous mode switching.
//  - Turns block/pixel statistics plus the active mode into {inv_en, shift, gain}
//    for post_process.
//  - Replaces the combinational mode decode in the fantasy top.
//  - Adds a registered pipeline stage, generic width parameters, and a
//    fade-out/fade-in gain ramp whenever the mode changes.
// PARAMETERS
//  MODE_W    3      width of mode_i; codes >= 8 decode as Pass
//  GAIN_W    18     gain_o width; unity = 32768 (Q2.15)
//  SHIFT_W   30     shift_o width, two's complement
//  RAMP_STEP 4096   ramp_gain change per frame during a fade (1..32768)
//  C_THRESH  89     px_C threshold for mode 4 (0.35 * 255)
// PORTS
//  vin_clk_i  in   1        pixel clock
//  rst_ni     in   1        synchronous active-low reset
//  vs_i       in   1        vertical sync; its rising edge is the frame boundary
//  mode_i     in   MODE_W   requested mode (async to frames; sampled only at frame boundary)
//  valid_i    in   1        pixel statistics valid this cycle
//  blk_Y_i    in   1        block luma flag
//  blk_C_i    in   1        block chroma flag
//  blk_L_i    in   1        block lightness flag
//  px_C_i     in   8        pixel chroma
//  px_L_i     in   8        pixel lightness
//  valid_o    out  1        valid_i delayed 1 cycle
//  inv_en_o   out  1        invert enable
//  shift_o    out  SHIFT_W  signed level shift
//  gain_o     out  GAIN_W   final gain = (pix_gain * ramp_gain) >> 15
//  fading_o   out  1        high while the fade FSM is not in STEADY
// BEHAVIOUR
//  - Reset (rst_ni=0 at clock edge):
//    - Outputs: valid_o=0, inv_en_o=0, shift_o=0, gain_o=32768, fading_o=0.
//    - State: FSM=STEADY, active_mode=7 (Pass), pending_mode=7, ramp_gain=32768.
//  - Latency: exactly 1 cycle from inputs to outputs.
//    - Outputs update every cycle, independent of valid_i.
//  - Frame boundary fb: vs_i=1 and vs_q=0, where vs_q is vs_i registered.
//    - mode_i is sampled into pending_mode only on fb.
//  - Decode of active_mode into pix_gain, inv, shift:
//    0: inv=1, g=32768
//    1: inv=1, g=21845
//    2: inv=blk_Y, g=32768
//    3: inv=~blk_C&blk_Y, g = blk_C ? 16384 : 32768
//    4: inv=0
//       - px_C<C_THRESH:
//         - blk_L=0: shift=0
//         - blk_L=1, L>=128: shift=(L-128)*2
//         - blk_L=1, L==127: shift=0
//         - blk_L=1, L<127: shift=(L-127)*2 (negative)
//         - g=32768
//       - px_C>=C_THRESH: shift=(L - C/2)/2, signed, truncation toward zero;
//         g = blk_L ? 21845 : 32768
//    5: g=13763
//    6: g=21845
//    7 and above: Pass, g=32768
//    shift=0 and inv=0 unless stated above.
//  - Gain product: 18x16-bit unsigned, shifted right 15, truncated.
//    - Never exceeds pix_gain.
//    - No saturation is needed.
//  - Fade FSM (evaluated only on fb):
//    - STEADY: if pending!=active, go to FADE_OUT.
//    - FADE_OUT: ramp_gain -= RAMP_STEP, floored at 0.
//      - On the fb where ramp_gain==0: active_mode <= pending_mode, go to FADE_IN.
//    - FADE_IN:
//      - If pending!=active, go to FADE_OUT; ramp_gain is not reset.
//      - Otherwise ramp_gain += RAMP_STEP, capped at 32768.
//        - On the fb where ramp_gain==32768, go to STEADY.
//    - Mode change during FADE_OUT: only pending_mode updates.
//      - If pending returns to active, the fade continues to 0 and
//        re-enters the same mode.
//    - active_mode and ramp_gain change only on fb, so parameters never
//      change mid-frame.
//  - vs_i held high: only one fb (edge-detected).
//  - Reset mid-fade: immediately STEADY, Pass, unity gain.
// CONFIGURATION
//  FANTASY_MODE_FADE_EN
//   - Defined: FSM and ramp as above.
//   - Undefined: ramp_gain is a constant 32768 and fading_o is tied to 0.
//     - active_mode <= pending_mode on the fb after sampling, i.e. one frame
//       after the request.
// STRUCTURE
//  - fantasy_pkg:
//    - MODE_* localparams (0..7)
//    - UNITY_GAIN=32768
//    - GAIN_DIM2=21845, GAIN_HALF=16384, GAIN_DIM5=13763
//    - fade state encoding: STEADY=0, FADE_OUT=1, FADE_IN=2
//  - Sub-module fade_ctrl:
//    - Inputs: fb, pending_mode, active_mode.
//    - Outputs: active_mode, ramp_gain, fading.
//    - Whole module is excluded from build without FANTASY_MODE_FADE_EN.
//  - Top: decode, multiplier, output register.
// TESTING
//  1. Reset, then drive mode_i=7 -> gain_o=32768, inv_en_o=0, shift_o=0,
//     fading_o=0 the cycle after release.
//  2. Mode 4, C=50, blk_L=1:
//     - L=200 -> shift_o=144
//     - L=127 -> 0
//     - L=100 -> -54
//     - C=100, L=200 -> shift_o=75, gain_o=21845
//  3. With FADE_EN and RAMP_STEP=16384, switch 7->0:
//     - Frames 1,2 give ramp 16384, 0.
//     - Frame 3: active=0 (inv_en_o=1), ramp 16384.
//     - Frame 4: 32768, fading_o=0.
//  4. Request 0 mid-FADE_IN of mode 6 -> FSM goes to FADE_OUT from the
//     current ramp value, with no jump to 0.
//  5. Assert rst_ni=0 during FADE_OUT -> next cycle Pass, gain_o=32768,
//     fading_o=0.
//  6. Without FADE_EN, change mode mid-frame -> outputs stay unchanged
//     until the second fb; then the new decode applies with unity ramp.

Source files
------------

// File: rtl/mode_param_gen_pkg.sv
// Shared constants, fade state encoding and the per-mode parameter decode
// for the mode_param_gen tone-mapping block.
package mode_param_gen_pkg;

   localparam int unsigned MODE_0    = 0;
   localparam int unsigned MODE_1    = 1;
   localparam int unsigned MODE_2    = 2;
   localparam int unsigned MODE_3    = 3;
   localparam int unsigned MODE_4    = 4;
   localparam int unsigned MODE_5    = 5;
   localparam int unsigned MODE_6    = 6;
   localparam int unsigned MODE_PASS = 7;

   localparam int unsigned UNITY_GAIN = 32768;
   localparam int unsigned GAIN_DIM2  = 21845;
   localparam int unsigned GAIN_HALF  = 16384;
   localparam int unsigned GAIN_DIM5  = 13763;
   localparam int unsigned RAMP_W     = 16;

   typedef enum logic [1:0] {
      STEADY   = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } fade_state_e;

   // shift is a 10-bit two's complement value, sign-extended by the user
   typedef struct packed {
      logic        inv;
      logic [9:0]  shift;
      logic [15:0] gain;
   } decode_t;

   function automatic decode_t decode_mode(input logic [31:0] mode,
                                           input logic        blk_y,
                                           input logic        blk_c,
                                           input logic        blk_l,
                                           input logic [7:0]  px_c,
                                           input logic [7:0]  px_l,
                                           input logic [7:0]  c_thresh);
      decode_t           d;
      logic signed [9:0] diff;
      d    = '{inv: 1'b0, shift: 10'd0, gain: 16'(UNITY_GAIN)};
      diff = '0;
      case (mode)
         MODE_0: d.inv = 1'b1;
         MODE_1: begin
            d.inv  = 1'b1;
            d.gain = 16'(GAIN_DIM2);
         end
         MODE_2: d.inv = blk_y;
         MODE_3: begin
            d.inv  = ~blk_c & blk_y;
            d.gain = blk_c ? 16'(GAIN_HALF) : 16'(UNITY_GAIN);
         end
         MODE_4: begin
            if (px_c < c_thresh) begin
               // lightness around mid-grey; 127 itself is the dead point
               if (blk_l && px_l != 8'd127) begin
                  diff    = $signed({2'b00, px_l}) - ((px_l >= 8'd128) ? 10'sd128 : 10'sd127);
                  d.shift = diff <<< 1;
               end
            end else begin
               // halve with truncation toward zero: bias negatives by +1 first
               diff    = $signed({2'b00, px_l}) - $signed({3'b000, px_c[7:1]});
               diff    = diff + 10'(diff[9]);
               d.shift = diff >>> 1;
               d.gain  = blk_l ? 16'(GAIN_DIM2) : 16'(UNITY_GAIN);
            end
         end
         MODE_5:  d.gain = 16'(GAIN_DIM5);
         MODE_6:  d.gain = 16'(GAIN_DIM2);
         default: d = '{inv: 1'b0, shift: 10'd0, gain: 16'(UNITY_GAIN)};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mode_param_gen_if.sv
// Pixel statistics in / tone-mapping parameters out for mode_param_gen.
// master drives statistics and frame sync; slave (the generator) drives parameters.
interface mode_param_gen_if #(
   parameter int unsigned MODE_W  = 3,
   parameter int unsigned GAIN_W  = 18,
   parameter int unsigned SHIFT_W = 30
);
   logic               vs_i;
   logic [MODE_W-1:0]  mode_i;
   logic               valid_i;
   logic               blk_Y_i;
   logic               blk_C_i;
   logic               blk_L_i;
   logic [7:0]         px_C_i;
   logic [7:0]         px_L_i;
   logic               valid_o;
   logic               inv_en_o;
   logic [SHIFT_W-1:0] shift_o;
   logic [GAIN_W-1:0]  gain_o;
   logic               fading_o;

   modport master (
      output vs_i, mode_i, valid_i, blk_Y_i, blk_C_i, blk_L_i, px_C_i, px_L_i,
      input  valid_o, inv_en_o, shift_o, gain_o, fading_o
   );

   modport slave (
      input  vs_i, mode_i, valid_i, blk_Y_i, blk_C_i, blk_L_i, px_C_i, px_L_i,
      output valid_o, inv_en_o, shift_o, gain_o, fading_o
   );
endinterface

// File: rtl/mode_param_gen_fade_ctrl.sv
// Frame-synchronous fade controller: ramps gain to zero, swaps the active mode,
// ramps back to unity. Built only when FANTASY_MODE_FADE_EN is defined.
`ifdef FANTASY_MODE_FADE_EN
module mode_param_gen_fade_ctrl
   import mode_param_gen_pkg::*;
#(
   parameter int unsigned MODE_W    = 3,
   parameter int unsigned RAMP_STEP = 4096
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fb_i,
   input  logic [MODE_W-1:0] pending_mode_i,
   output logic [MODE_W-1:0] active_mode_o,
   output logic [RAMP_W-1:0] ramp_gain_o,
   output logic              fading_o
);
   fade_state_e       state_q, state_d;
   logic [MODE_W-1:0] active_mode_q, active_mode_d;
   logic [RAMP_W-1:0] ramp_q, ramp_d;
   logic [RAMP_W:0]   ramp_up;
   logic [RAMP_W-1:0] ramp_up_cap;
   logic [RAMP_W-1:0] ramp_down;

   always_comb begin
      state_d       = state_q;
      active_mode_d = active_mode_q;
      ramp_d        = ramp_q;
      ramp_up       = {1'b0, ramp_q} + (RAMP_W+1)'(RAMP_STEP);
      ramp_up_cap   = (ramp_up >= (RAMP_W+1)'(UNITY_GAIN)) ? RAMP_W'(UNITY_GAIN)
                                                           : ramp_up[RAMP_W-1:0];
      ramp_down     = (ramp_q > RAMP_W'(RAMP_STEP)) ? ramp_q - RAMP_W'(RAMP_STEP) : '0;
      if (fb_i) begin
         unique case (state_q)
            STEADY: if (pending_mode_i != active_mode_q) state_d = FADE_OUT;
            FADE_OUT: begin
               // the swap happens on the same boundary the ramp bottoms out
               ramp_d = ramp_down;
               if (ramp_down == '0) begin
                  active_mode_d = pending_mode_i;
                  state_d       = FADE_IN;
               end
            end
            FADE_IN: begin
               if (pending_mode_i != active_mode_q) begin
                  state_d = FADE_OUT;
               end else begin
                  ramp_d = ramp_up_cap;
                  if (ramp_up_cap == RAMP_W'(UNITY_GAIN)) state_d = STEADY;
               end
            end
            default: state_d = STEADY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= STEADY;
         active_mode_q <= MODE_W'(MODE_PASS);
         ramp_q        <= RAMP_W'(UNITY_GAIN);
      end else begin
         state_q       <= state_d;
         active_mode_q <= active_mode_d;
         ramp_q        <= ramp_d;
      end
   end

   assign active_mode_o = active_mode_q;
   assign ramp_gain_o   = ramp_q;
   assign fading_o      = (state_q != STEADY);
endmodule
`endif

// File: rtl/mode_param_gen.sv
// Tone-mapping parameter generator: frame-synchronous mode switch, decode, gain
// product and one output register stage. FANTASY_MODE_FADE_EN enables the gain ramp.
module mode_param_gen
   import mode_param_gen_pkg::*;
#(
   parameter int unsigned MODE_W    = 3,
   parameter int unsigned GAIN_W    = 18,
   parameter int unsigned SHIFT_W   = 30,
   parameter int unsigned RAMP_STEP = 4096,
   parameter int unsigned C_THRESH  = 89
) (
   input  logic            vin_clk_i,
   input  logic            rst_ni,
   mode_param_gen_if.slave bus
);
   logic                     vs_q, vs_d;
   logic                     fb;
   logic [MODE_W-1:0]        pending_mode_q, pending_mode_d;
   logic [MODE_W-1:0]        active_mode;
   logic [RAMP_W-1:0]        ramp_gain;
   logic                     fading;
   decode_t                  dec;
   logic [GAIN_W+RAMP_W-1:0] product;
   logic                     valid_q, valid_d;
   logic                     inv_en_q, inv_en_d;
   logic                     fading_q, fading_d;
   logic [SHIFT_W-1:0]       shift_q, shift_d;
   logic [GAIN_W-1:0]        gain_q, gain_d;

   assign fb = bus.vs_i & ~vs_q;

   always_comb begin
      vs_d           = bus.vs_i;
      pending_mode_d = fb ? bus.mode_i : pending_mode_q;
   end

`ifdef FANTASY_MODE_FADE_EN
   mode_param_gen_fade_ctrl #(
      .MODE_W    (MODE_W),
      .RAMP_STEP (RAMP_STEP)
   ) u_fade_ctrl (
      .clk_i          (vin_clk_i),
      .rst_ni         (rst_ni),
      .fb_i           (fb),
      .pending_mode_i (pending_mode_q),
      .active_mode_o  (active_mode),
      .ramp_gain_o    (ramp_gain),
      .fading_o       (fading)
   );
`else
   logic [MODE_W-1:0] active_mode_q, active_mode_d;

   // a request lands in pending on one boundary and goes live on the next
   always_comb active_mode_d = fb ? pending_mode_q : active_mode_q;

   always_ff @(posedge vin_clk_i) begin
      if (!rst_ni) active_mode_q <= MODE_W'(MODE_PASS);
      else         active_mode_q <= active_mode_d;
   end

   assign active_mode = active_mode_q;
   assign ramp_gain   = RAMP_W'(UNITY_GAIN);
   assign fading      = 1'b0;
`endif

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      dec      = decode_mode(32'(active_mode), bus.blk_Y_i, bus.blk_C_i, bus.blk_L_i,
                             bus.px_C_i, bus.px_L_i, 8'(C_THRESH));
      product  = (GAIN_W+RAMP_W)'(dec.gain) * (GAIN_W+RAMP_W)'(ramp_gain);
      valid_d  = bus.valid_i;
      inv_en_d = dec.inv;
      shift_d  = {{(SHIFT_W-10){dec.shift[9]}}, dec.shift};
      gain_d   = GAIN_W'(product >> 15);
      fading_d = fading;
   end

   // NOTE: synchronous reset sits inside the clocked block, and all state uses
   // non-blocking assignments so each flop samples pre-edge values.
   always_ff @(posedge vin_clk_i) begin
      if (!rst_ni) begin
         vs_q           <= 1'b0;
         pending_mode_q <= MODE_W'(MODE_PASS);
         valid_q        <= 1'b0;
         inv_en_q       <= 1'b0;
         shift_q        <= '0;
         gain_q         <= GAIN_W'(UNITY_GAIN);
         fading_q       <= 1'b0;
      end else begin
         vs_q           <= vs_d;
         pending_mode_q <= pending_mode_d;
         valid_q        <= valid_d;
         inv_en_q       <= inv_en_d;
         shift_q        <= shift_d;
         gain_q         <= gain_d;
         fading_q       <= fading_d;
      end
   end

   assign bus.valid_o  = valid_q;
   assign bus.inv_en_o = inv_en_q;
   assign bus.shift_o  = shift_q;
   assign bus.gain_o   = gain_q;
   assign bus.fading_o = fading_q;
endmodule
